// File: rtl/spi_pkg.sv
// Shared types and constants for the receive-only SPI master.
package spi_pkg;
  localparam int FRAME_W      = 8;
  localparam int IDX_W        = 4;
  localparam int SCK_HALF_DEF = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/spi_master_rx_unit_if.sv
// Host request/response and SPI pin bundle for spi_master_rx_unit.
interface spi_master_rx_unit_if;
  import spi_pkg::*;

  logic               get;
  logic [FRAME_W-1:0] data;
  logic               busy;
  logic               rdy;
  logic               sck;
  logic               ss;
  logic               miso;

  modport master (input get, miso, output data, busy, rdy, sck, ss);
  modport slave  (output get, miso, input data, busy, rdy, sck, ss);
endinterface

// File: rtl/spi_sck_div.sv
// Half-period counter: tick pulses on every SCK_HALF-th enabled clk.
module spi_sck_div #(
  parameter int SCK_HALF = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int CNT_W = (SCK_HALF > 2) ? $clog2(SCK_HALF) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_W'(SCK_HALF - 1));

  // Held at zero while disabled so every frame and gap starts a full half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (!en || tick)    cnt <= '0;
    else                     cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/spi_master_rx_unit.sv
// Receive-only SPI master, mode 0, MSB first, 8-bit frames with rdy strobe.
module spi_master_rx_unit
  import spi_pkg::*;
#(
  parameter int SCK_HALF = SCK_HALF_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_master_rx_unit_if.master bus,
  output logic [1:0]          _dbg_cs,
  output logic [IDX_W-1:0]    _dbg_idx,
  output logic [FRAME_W-1:0]  _dbg_buff
);
  state_t             state, state_nxt;
  logic               ss_q, ss_nxt;
  logic               sck_q, sck_nxt;
  logic               busy_q, busy_nxt;
  logic               rdy_q, rdy_nxt;
  logic [FRAME_W-1:0] data_q, data_nxt;
  logic [FRAME_W-1:0] buff_q, buff_nxt;
  logic [IDX_W-1:0]   idx_q, idx_nxt;
  logic               div_en, tick;

  assign div_en = (state == XFER) || (state == DONE);

  spi_sck_div #(.SCK_HALF(SCK_HALF)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (div_en),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q   <= 1'b1;
      sck_q  <= 1'b0;
      busy_q <= 1'b0;
      rdy_q  <= 1'b0;
      data_q <= '0;
      buff_q <= '0;
      idx_q  <= '0;
    end else begin
      ss_q   <= ss_nxt;
      sck_q  <= sck_nxt;
      busy_q <= busy_nxt;
      rdy_q  <= rdy_nxt;
      data_q <= data_nxt;
      buff_q <= buff_nxt;
      idx_q  <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ss_nxt    = ss_q;
    sck_nxt   = sck_q;
    busy_nxt  = busy_q;
    rdy_nxt   = 1'b0;
    data_nxt  = data_q;
    buff_nxt  = buff_q;
    idx_nxt   = idx_q;
    case (state)
      IDLE: begin
        ss_nxt   = 1'b1;
        sck_nxt  = 1'b0;
        busy_nxt = 1'b0;
        if (bus.get) begin
          state_nxt = XFER;
          ss_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          idx_nxt   = '0;
          buff_nxt  = '0;
        end
      end
      XFER: begin
        if (tick) begin
          if (!sck_q) begin
            // Rising edge: the slave set miso on the previous falling edge.
            sck_nxt  = 1'b1;
            buff_nxt = {buff_q[FRAME_W-2:0], bus.miso};
            idx_nxt  = idx_q + IDX_W'(1);
          end else if (idx_q == IDX_W'(FRAME_W)) begin
            state_nxt = DONE;
            ss_nxt    = 1'b1;
            sck_nxt   = 1'b0;
            data_nxt  = buff_q;
            rdy_nxt   = 1'b1;
          end else begin
            sck_nxt = 1'b0;
          end
        end
      end
      DONE: begin
        ss_nxt  = 1'b1;
        sck_nxt = 1'b0;
        if (tick) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        ss_nxt    = 1'b1;
        sck_nxt   = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.ss    = ss_q;
  assign bus.sck   = sck_q;
  assign bus.busy  = busy_q;
  assign bus.rdy   = rdy_q;
  assign bus.data  = data_q;
  assign _dbg_cs   = state;
  assign _dbg_idx  = idx_q;
  assign _dbg_buff = buff_q;
endmodule

// File: tb/tb_spi_master_rx_unit.sv
// Scoreboard bench for spi_master_rx_unit: expected bytes queued at request time.
module tb_spi_master_rx_unit;
  localparam int H          = 5;
  localparam int FRAME_CLKS = 16 * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_rx_unit_if iface();
  logic [1:0] dbg_cs;
  logic [3:0] dbg_idx;
  logic [7:0] dbg_buff;

  spi_master_rx_unit #(.SCK_HALF(H)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (iface),
    ._dbg_cs  (dbg_cs),
    ._dbg_idx (dbg_idx),
    ._dbg_buff(dbg_buff)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  // Passive monitor: edge counts and run lengths sampled on the falling clk edge.
  logic prev_sck = 1'b0, prev_ss = 1'b1, prev_rdy = 1'b0;
  int sck_rises = 0, ss_falls = 0, rdy_pulses = 0;
  int ss_low_run = 0, ss_high_run = 0, last_ss_low = 0, last_ss_gap = 0;
  int rdy_run = 0, last_rdy_len = 0;

  always @(negedge clk) begin
    if (iface.sck === 1'b1 && !prev_sck) sck_rises++;
    if (iface.ss === 1'b0 && prev_ss) begin ss_falls++; last_ss_gap = ss_high_run; end
    if (iface.ss === 1'b1 && !prev_ss) last_ss_low = ss_low_run;
    if (iface.ss === 1'b1) begin ss_high_run++; ss_low_run = 0; end
    else begin ss_low_run++; ss_high_run = 0; end
    if (iface.rdy === 1'b1) begin
      rdy_run++;
      if (!prev_rdy) rdy_pulses++;
    end else begin
      if (prev_rdy) last_rdy_len = rdy_run;
      rdy_run = 0;
    end
    prev_sck = (iface.sck === 1'b1);
    prev_ss  = (iface.ss === 1'b1);
    prev_rdy = (iface.rdy === 1'b1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rdy(input int budget, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      cycles = i + 1;
      if (iface.rdy === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * H + 8; i++) begin
      if (iface.busy === 1'b0 && dbg_cs == 2'd0) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iface.get = 1'b0; iface.miso = 1'b0;
    repeat (3) step();
    n_cmp++; if (iface.ss !== 1'b1) begin n_bad++; $display("FAIL reset_ss: got %b want 1", iface.ss); end
    n_cmp++; if (iface.sck !== 1'b0) begin n_bad++; $display("FAIL reset_sck: got %b want 0", iface.sck); end
    n_cmp++; if (iface.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", iface.busy); end
    n_cmp++; if (iface.rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b want 0", iface.rdy); end
    n_cmp++; if (iface.data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", iface.data); end
    n_cmp++; if (dbg_cs !== 2'd0) begin n_bad++; $display("FAIL reset_cs: got %0d want 0", dbg_cs); end
    n_cmp++; if (dbg_buff !== 8'h00) begin n_bad++; $display("FAIL reset_buff: got %h want 00", dbg_buff); end
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_all_ones();
    bit ok; int cyc; int r0;
    logic [7:0] exp;
    iface.miso = 1'b1;
    r0 = sck_rises;
    exp_q.push_back(8'hFF);
    iface.get = 1'b1;
    wait_rdy(FRAME_CLKS + 10, ok, cyc);
    iface.get = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ones_rdy: seen %0b want 1", ok); end
    exp = exp_q.pop_front();
    n_cmp++; if (iface.data !== exp) begin n_bad++; $display("FAIL ones_data: got %h want %h", iface.data, exp); end
    n_cmp++; if (cyc != FRAME_CLKS + 1) begin n_bad++; $display("FAIL ones_latency: got %0d want %0d", cyc, FRAME_CLKS + 1); end
    n_cmp++; if (dbg_buff !== 8'hFF) begin n_bad++; $display("FAIL ones_buff: got %h want ff", dbg_buff); end
    step();
    n_cmp++; if (sck_rises - r0 != 8) begin n_bad++; $display("FAIL ones_sck_rises: got %0d want 8", sck_rises - r0); end
    n_cmp++; if (last_ss_low != FRAME_CLKS) begin n_bad++; $display("FAIL ones_ss_low: got %0d want %0d", last_ss_low, FRAME_CLKS); end
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ones_idle: reached %0b want 1", ok); end
  endtask

  task automatic test_alternating();
    bit ok; bit prev_s;
    logic [7:0] exp;
    ok = 1'b0; prev_s = 1'b0;
    iface.miso = 1'b1;
    exp_q.push_back(8'hAA);
    iface.get = 1'b1;
    for (int i = 0; i < FRAME_CLKS + 10; i++) begin
      step();
      if (prev_s && iface.sck === 1'b0) iface.miso = ~iface.miso;
      prev_s = (iface.sck === 1'b1);
      if (iface.rdy === 1'b1) begin ok = 1'b1; break; end
    end
    iface.get = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL alt_rdy: seen %0b want 1", ok); end
    exp = exp_q.pop_front();
    n_cmp++; if (iface.data !== exp) begin n_bad++; $display("FAIL alt_data: got %h want %h", iface.data, exp); end
    step();
    n_cmp++; if (iface.rdy !== 1'b0) begin n_bad++; $display("FAIL alt_rdy_drop: got %b want 0", iface.rdy); end
    n_cmp++; if (last_rdy_len != 1) begin n_bad++; $display("FAIL alt_rdy_width: got %0d want 1", last_rdy_len); end
    wait_idle(ok);
  endtask

  task automatic test_drop_get();
    bit ok; int cyc; int r0; int f0;
    logic [7:0] exp;
    iface.miso = 1'b0;
    r0 = sck_rises; f0 = ss_falls;
    exp_q.push_back(8'h00);
    iface.get = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8 * H; i++) begin
      step();
      if (sck_rises - r0 >= 3) begin ok = 1'b1; break; end
    end
    iface.get = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL drop_three_rises: seen %0b want 1", ok); end
    wait_rdy(FRAME_CLKS + 10, ok, cyc);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL drop_rdy: seen %0b want 1", ok); end
    exp = exp_q.pop_front();
    n_cmp++; if (iface.data !== exp) begin n_bad++; $display("FAIL drop_data: got %h want %h", iface.data, exp); end
    repeat (H + 2) step();
    n_cmp++; if (iface.busy !== 1'b0) begin n_bad++; $display("FAIL drop_busy: got %b want 0", iface.busy); end
    n_cmp++; if (dbg_cs !== 2'd0) begin n_bad++; $display("FAIL drop_cs: got %0d want 0", dbg_cs); end
    n_cmp++; if (ss_falls - f0 != 1) begin n_bad++; $display("FAIL drop_frames: got %0d want 1", ss_falls - f0); end
  endtask

  task automatic test_back_to_back();
    bit ok; int cyc; int f0; int p0;
    logic [7:0] exp;
    iface.miso = 1'b0;
    f0 = ss_falls; p0 = rdy_pulses;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    iface.get = 1'b1;
    wait_rdy(FRAME_CLKS + 10, ok, cyc);
    iface.miso = 1'b1;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_rdy1: seen %0b want 1", ok); end
    exp = exp_q.pop_front();
    n_cmp++; if (iface.data !== exp) begin n_bad++; $display("FAIL b2b_data1: got %h want %h", iface.data, exp); end
    ok = 1'b0;
    for (int i = 0; i < 3 * H + 4; i++) begin
      step();
      if (ss_falls - f0 >= 2) begin ok = 1'b1; break; end
    end
    iface.get = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_restart: seen %0b want 1", ok); end
    wait_rdy(FRAME_CLKS + 10, ok, cyc);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_rdy2: seen %0b want 1", ok); end
    exp = exp_q.pop_front();
    n_cmp++; if (iface.data !== exp) begin n_bad++; $display("FAIL b2b_data2: got %h want %h", iface.data, exp); end
    step();
    n_cmp++; if (ss_falls - f0 != 2) begin n_bad++; $display("FAIL b2b_ss_falls: got %0d want 2", ss_falls - f0); end
    n_cmp++; if (rdy_pulses - p0 != 2) begin n_bad++; $display("FAIL b2b_rdy_pulses: got %0d want 2", rdy_pulses - p0); end
    n_cmp++; if (last_ss_gap < H) begin n_bad++; $display("FAIL b2b_ss_gap: got %0d want >= %0d", last_ss_gap, H); end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    bit ok; int cyc; int p0; int r0;
    logic [7:0] exp;
    iface.miso = 1'b1;
    p0 = rdy_pulses;
    iface.get = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      step();
      if (dbg_idx == 4'd4) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_idx4: seen %0b want 1", ok); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (iface.ss !== 1'b1) begin n_bad++; $display("FAIL rmid_ss: got %b want 1", iface.ss); end
    n_cmp++; if (iface.sck !== 1'b0) begin n_bad++; $display("FAIL rmid_sck: got %b want 0", iface.sck); end
    n_cmp++; if (iface.busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", iface.busy); end
    n_cmp++; if (iface.data !== 8'h00) begin n_bad++; $display("FAIL rmid_data: got %h want 00", iface.data); end
    n_cmp++; if (dbg_idx !== 4'd0) begin n_bad++; $display("FAIL rmid_idx: got %0d want 0", dbg_idx); end
    iface.get = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2 * H) step();
    n_cmp++; if (rdy_pulses - p0 != 0) begin n_bad++; $display("FAIL rmid_no_rdy: got %0d want 0", rdy_pulses - p0); end
    r0 = sck_rises;
    exp_q.push_back(8'hFF);
    iface.get = 1'b1;
    wait_rdy(FRAME_CLKS + 10, ok, cyc);
    iface.get = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_clean_rdy: seen %0b want 1", ok); end
    exp = exp_q.pop_front();
    n_cmp++; if (iface.data !== exp) begin n_bad++; $display("FAIL rmid_clean_data: got %h want %h", iface.data, exp); end
    n_cmp++; if (cyc != FRAME_CLKS + 1) begin n_bad++; $display("FAIL rmid_clean_latency: got %0d want %0d", cyc, FRAME_CLKS + 1); end
    n_cmp++; if (sck_rises - r0 != 8) begin n_bad++; $display("FAIL rmid_clean_rises: got %0d want 8", sck_rises - r0); end
    wait_idle(ok);
  endtask

  initial begin
    iface.get  = 1'b0;
    iface.miso = 1'b0;
    test_reset();
    test_all_ones();
    test_alternating();
    test_drop_get();
    test_back_to_back();
    test_reset_mid();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_empty: left %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
